baccarat_fsm: RTL and testbench

- Control state machine for the baccarat card table.
- Sequences six card-register load strobes: player cards 1-3 and dealer cards 1-3. The card registers feed the per-card 7-segment decoders and the score datapath.
- Applies the third-card drawing rules to the running scores from the datapath.
- Drives the player and dealer win lights.
- Advances exactly one state per rising edge of slow_clock, which is the debounced step button.

---
 rtl/baccarat_pkg.sv | 12 +
 rtl/baccarat_banker_rule.sv | 21 ++
 rtl/baccarat_fsm.sv | 62 ++++++
 tb/tb_baccarat_fsm.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/baccarat_pkg.sv
// baccarat_pkg: shared state encoding, drawing-rule constants and card value helper
package baccarat_pkg;
  typedef enum logic [3:0] {
    S_P1, S_D1, S_P2, S_D2, S_EVAL, S_P3, S_EVAL3, S_D3, S_DONE
  } state_e;
  localparam int NATURAL_MIN = 8;
  localparam int PLAYER_STAND_MIN = 6;
  localparam int BANKER_STAND_MIN = 7;
  function automatic logic [3:0] card_value(input logic [3:0] card);
    return (card >= 4'd1 && card <= 4'd9) ? card : 4'd0;
  endfunction
endpackage

// File: rtl/baccarat_banker_rule.sv
// banker_rule: combinational banker third-card decision
// dscore: dealer two-card score; pcard3: raw player third card; banker_draw: dealer takes a third card
module banker_rule
  import baccarat_pkg::*;
#(
  parameter int CARD_W = 4,
  parameter int SCORE_W = 4
) (
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               banker_draw
);
  logic [3:0] v;
  assign v = card_value(pcard3);
  assign banker_draw = dscore <= SCORE_W'(2)                ? 1'b1 :
                       dscore >= SCORE_W'(BANKER_STAND_MIN) ? 1'b0 :
                       dscore == SCORE_W'(3)                ? v != 4'd8 :
                       dscore == SCORE_W'(4)                ? (v >= 4'd2 && v <= 4'd7) :
                       dscore == SCORE_W'(5)                ? (v >= 4'd4 && v <= 4'd7) :
                                                              (v >= 4'd6 && v <= 4'd7);
endmodule

// File: rtl/baccarat_fsm.sv
// baccarat_fsm: baccarat table control FSM, one state per slow_clock edge
// slow_clock/reset: step clock and async active-high reset; pscore/dscore/pcard3: datapath feedback
// load_*: one-hot card register load strobes; *_win_light: result lights, both lit on a tie
module baccarat_fsm
  import baccarat_pkg::*;
#(
  parameter int CARD_W = 4,
  parameter int SCORE_W = 4
) (
  input  logic               slow_clock,
  input  logic               reset,
  input  logic [SCORE_W-1:0] pscore,
  input  logic [SCORE_W-1:0] dscore,
  input  logic [CARD_W-1:0]  pcard3,
  output logic               load_pcard1,
  output logic               load_pcard2,
  output logic               load_pcard3,
  output logic               load_dcard1,
  output logic               load_dcard2,
  output logic               load_dcard3,
  output logic               player_win_light,
  output logic               dealer_win_light
);
  state_e state_q, state_d;
  logic banker_draw, natural, done;
  banker_rule #(.CARD_W(CARD_W), .SCORE_W(SCORE_W)) u_banker_rule (
    .dscore(dscore),
    .pcard3(pcard3),
    .banker_draw(banker_draw)
  );
  assign natural = pscore >= SCORE_W'(NATURAL_MIN) || dscore >= SCORE_W'(NATURAL_MIN);
  always_ff @(posedge slow_clock or posedge reset)
    if (reset) state_q <= S_P1;
    else state_q <= state_d;
  always_comb begin
    state_d = S_P1;
    case (state_q)
      S_P1:    state_d = S_D1;
      S_D1:    state_d = S_P2;
      S_P2:    state_d = S_D2;
      S_D2:    state_d = S_EVAL;
      // a standing player leaves the banker on the simple 0-5 draw rule
      S_EVAL:  state_d = natural ? S_DONE :
                         pscore < SCORE_W'(PLAYER_STAND_MIN) ? S_P3 :
                         dscore <= SCORE_W'(5) ? S_D3 : S_DONE;
      S_P3:    state_d = S_EVAL3;
      S_EVAL3: state_d = banker_draw ? S_D3 : S_DONE;
      S_D3:    state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_P1;
    endcase
  end
  assign done = state_q == S_DONE;
  assign load_pcard1 = state_q == S_P1;
  assign load_pcard2 = state_q == S_P2;
  assign load_pcard3 = state_q == S_P3;
  assign load_dcard1 = state_q == S_D1;
  assign load_dcard2 = state_q == S_D2;
  assign load_dcard3 = state_q == S_D3;
  assign player_win_light = done && pscore >= dscore;
  assign dealer_win_light = done && dscore >= pscore;
endmodule

// File: tb/tb_baccarat_fsm.sv
// tb_baccarat_fsm: scoreboard bench driving whole games against a card-level reference model
module tb_baccarat_fsm;
  logic slow_clock = 1'b0;
  logic reset = 1'b1;
  logic [3:0] pscore = '0, dscore = '0, pcard3 = '0;
  logic load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3;
  logic player_win_light, dealer_win_light;
  logic [3:0] br_d = '0, br_c = '0;
  logic br_o;
  logic [7:0] act;
  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  localparam bit [9:0] DRAW_MASK [10] = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h2FF, 10'h0FC,
                                          10'h0F0, 10'h0C0, 10'h000, 10'h000, 10'h000};
  always #5 slow_clock = ~slow_clock;
  baccarat_fsm #(.CARD_W(4), .SCORE_W(4)) dut (
    .slow_clock(slow_clock),
    .reset(reset),
    .pscore(pscore),
    .dscore(dscore),
    .pcard3(pcard3),
    .load_pcard1(load_pcard1),
    .load_pcard2(load_pcard2),
    .load_pcard3(load_pcard3),
    .load_dcard1(load_dcard1),
    .load_dcard2(load_dcard2),
    .load_dcard3(load_dcard3),
    .player_win_light(player_win_light),
    .dealer_win_light(dealer_win_light)
  );
  banker_rule #(.CARD_W(4), .SCORE_W(4)) u_br (.dscore(br_d), .pcard3(br_c), .banker_draw(br_o));
  assign act = {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3,
                player_win_light, dealer_win_light};
  function automatic int cv(input int c);
    return (c >= 1 && c <= 9) ? c : 0;
  endfunction
  function automatic bit m_draw(input int d, input int v);
    return d <= 9 ? DRAW_MASK[d][v] : 1'b0;
  endfunction
  function automatic int score(input int c[3], input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += cv(c[i]);
    return s % 10;
  endfunction
  function automatic logic [7:0] vec(input int code, input int ps, input int ds);
    if (code >= 1 && code <= 6) return 8'h80 >> (code - 1);
    if (code == 7) return {6'b0, ps >= ds, ds >= ps};
    return 8'h00;
  endfunction
  always @(negedge slow_clock)
    if (exp_q.size() > 0) begin
      automatic logic [7:0] e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL outputs at %0t: got %b expected %b", $time, act, e);
      end
    end
  task automatic check_now(input string name, input logic [7:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, e);
    end
  endtask
  task automatic do_reset();
    reset = 1'b1;
    #1 check_now("async reset", 8'h80);
    @(posedge slow_clock);
    #1 check_now("reset held", 8'h80);
    reset = 1'b0;
  endtask
  // codes: 1..3 player card strobes, 4..6 dealer card strobes, 0 evaluation, 7 done
  task automatic play(input int p[3], input int d[3], input int extra, input int abort_code);
    int steps[$];
    int np = 0, nd = 0, ps, ds, ps2, ds2;
    bit nat, pdr, ddr;
    ps2 = score(p, 2);
    ds2 = score(d, 2);
    nat = ps2 >= 8 || ds2 >= 8;
    pdr = !nat && ps2 <= 5;
    ddr = !nat && (pdr ? m_draw(ds2, cv(p[2])) : ds2 <= 5);
    steps = '{1, 4, 2, 5, 0};
    if (pdr) begin
      steps.push_back(3);
      steps.push_back(0);
    end
    if (ddr) steps.push_back(6);
    for (int i = 0; i <= extra; i++) steps.push_back(7);
    foreach (steps[k]) begin
      if (k > 0) begin
        @(posedge slow_clock);
        #1;
      end
      ps = score(p, np);
      ds = score(d, nd);
      pscore = 4'(ps);
      dscore = 4'(ds);
      pcard3 = 4'(p[2]);
      exp_q.push_back(vec(steps[k], ps, ds));
      if (steps[k] >= 1 && steps[k] <= 3) np++;
      else if (steps[k] >= 4 && steps[k] <= 6) nd++;
      if (steps[k] == abort_code) begin
        @(negedge slow_clock);
        #2;
        return;
      end
    end
    @(negedge slow_clock);
    #1;
  endtask
  initial begin
    for (int d = 0; d < 16; d++)
      for (int c = 0; c < 16; c++) begin
        br_d = 4'(d);
        br_c = 4'(c);
        #1;
        checks++;
        if (br_o !== m_draw(d, cv(c))) begin
          errors++;
          $display("FAIL banker_rule d=%0d c=%0d: got %b expected %b", d, c, br_o, m_draw(d, cv(c)));
        end
      end
    do_reset();
    play('{3, 5, 0}, '{1, 2, 0}, 10, -1);
    do_reset();
    play('{2, 3, 8}, '{1, 2, 0}, 2, -1);
    do_reset();
    play('{2, 4, 0}, '{1, 3, 5}, 2, -1);
    do_reset();
    play('{1, 2, 12}, '{2, 4, 0}, 2, -1);
    do_reset();
    play('{1, 2, 7}, '{2, 4, 13}, 2, -1);
    do_reset();
    play('{1, 2, 7}, '{2, 4, 13}, 0, 3);
    do_reset();
    play('{1, 1, 1}, '{1, 1, 1}, 1, -1);
    for (int g = 0; g < 60; g++) begin
      automatic int p[3], d[3];
      for (int i = 0; i < 3; i++) begin
        p[i] = int'($urandom_range(0, 15));
        d[i] = int'($urandom_range(0, 15));
      end
      do_reset();
      play(p, d, int'($urandom_range(0, 2)), -1);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
